load_align_unit: RTL

Parametrised load-path unit between the memory data register and the register file. It replaces fixed byte/half/word zero-extension with size- and offset-aware extraction, optional sign extension, and a two-beat read that merges misaligned loads spanning two memory words. It issues its own word-aligned memory reads through a level request / valid-response handshake.

---
 rtl/load_align_unit.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/load_align_unit.sv
// Load alignment unit: size/offset-aware extraction with sign extension,
// issuing one or two word-aligned reads and merging loads that cross a word.
module load_align_unit #(
  parameter int DATA_WIDTH       = 32,
  parameter int ADDR_WIDTH       = 32,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_valid,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [1:0] {
    IDLE, READ1, READ2, FINISH
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [OW-1:0]         off_q, off_d;
  logic [1:0]            size_q, size_d;
  logic                  sext_q, sext_d;
  logic                  split_q, split_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  req_split;
  logic                  req_ok;
  logic [DATA_WIDTH-1:0] raw;
  logic [DATA_WIDTH-1:0] ext;
  logic [3:0]            nbytes;
  logic                  sbit;

  assign req_split = (int'(addr[OW-1:0]) + (1 << size)) > NB;
  assign req_ok    = (int'(size) <= OW) &&
                     (ALLOW_MISALIGNED || !req_split);

  // Two-word window shifted down so the first wanted byte sits at byte 0
  assign raw    = DATA_WIDTH'({hi_q, lo_q} >> {off_q, 3'b000});
  assign nbytes = 4'd1 << size_q;

  always_comb begin
    sbit = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (i == int'(nbytes) - 1) sbit = raw[8*i+7];
    end
    sbit = sbit & sext_q;
    ext  = '0;
    for (int i = 0; i < NB; i++) begin
      ext[8*i +: 8] = (i < int'(nbytes)) ? raw[8*i +: 8] : {8{sbit}};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      base_q  <= '0;
      off_q   <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      split_q <= 1'b0;
      lo_q    <= '0;
      hi_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      off_q   <= off_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      split_q <= split_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    off_d   = off_q;
    size_d  = size_q;
    sext_d  = sext_q;
    split_d = split_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (!req_ok) begin
            err_d = 1'b1;
          end else begin
            state_d = READ1;
            base_d  = {addr[ADDR_WIDTH-1:OW], {OW{1'b0}}};
            off_d   = addr[OW-1:0];
            size_d  = size;
            sext_d  = sign_ext;
            split_d = req_split;
            hi_d    = '0;
          end
        end
      end
      READ1: begin
        if (mem_valid) begin
          lo_d    = mem_rdata;
          state_d = split_q ? READ2 : FINISH;
        end
      end
      READ2: begin
        if (mem_valid) begin
          hi_d    = mem_rdata;
          state_d = FINISH;
        end
      end
      FINISH: begin
        dout_d  = ext;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_rd   = 1'b0;
    mem_addr = '0;
    busy     = (state_q != IDLE);
    unique case (state_q)
      READ1: begin
        mem_rd   = 1'b1;
        mem_addr = base_q;
      end
      READ2: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + ADDR_WIDTH'(NB);
      end
      default: begin
        mem_rd   = 1'b0;
        mem_addr = '0;
      end
    endcase
  end

  assign done     = done_q;
  assign err      = err_q;
  assign data_out = dout_q;

endmodule
